tdc_readout: RTL and testbench

- Read-side counterpart of the TDC response memory.
- The capture path writes T carry-chain snapshots (N bits each) into the response RAM. This block walks that RAM from address 0 to T-1 and converts each thermometer-coded snapshot into a binary hit count.
- Each result is presented on a valid/ready stream for the host/readout logic, with a per-word flag marking non-thermometer (bubbled) captures.
- Runs in the readout clock domain; the RAM read port and this block share that single clock.

---
 rtl/tdc_readout.sv | 164 ++++++++++++++++
 tb/tb_tdc_readout.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_readout.sv
// tdc_readout - read-side walker for the TDC response RAM.
//
// Walks RAM addresses 0..T-1 once per accepted start, turns each N-bit
// carry-chain snapshot into a hit count (popcount) and flags snapshots that
// are not LSB-contiguous thermometer codes. Results leave on a valid/ready
// stream. Single clock domain shared with the RAM read port.
//
// Ports:
//   clock, reset      readout clock, asynchronous active-high reset
//   start             one-cycle pass request, honoured only when idle
//   busy              high while a pass is in progress (not in its done cycle)
//   done              one-cycle pulse after the last result is accepted
//   rd_addr, rd_data  RAM read port; data valid RD_LATENCY cycles after addr
//   out_valid/ready   result handshake
//   out_idx           snapshot index of the presented result
//   out_count         number of ones in the snapshot (0..N)
//   out_bubble        snapshot is not of the form 0..01..1
//
// Optional build macro TDC_READOUT_MINMAX_EN adds min_count / max_count,
// the minimum and maximum out_count seen over the current pass.
module tdc_readout #(
  parameter int N          = 16,
  parameter int T          = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(T)-1:0]     rd_addr,
  input  logic [N-1:0]             rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(T)-1:0]     out_idx,
  output logic [$clog2(N+1)-1:0]   out_count,
  output logic                     out_bubble
`ifdef TDC_READOUT_MINMAX_EN
  ,
  output logic [$clog2(N+1)-1:0]   min_count,
  output logic [$clog2(N+1)-1:0]   max_count
`endif
);

  localparam int AW = $clog2(T);
  localparam int CW = $clog2(N+1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(T - 1);
  localparam logic [1:0]    WAIT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [N-1:0]  ONE_N     = N'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT, S_DONE} state_t;

  state_t     state;
  state_t     state_n;
  logic [1:0] wcnt;
  logic       wait_last;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] w);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(w[i]);
    end
    return c;
  endfunction

  // A clean thermometer code plus one is a power of two (or wraps to zero),
  // so ANDing with the original clears every bit only for clean codes.
  function automatic logic is_bubbled(input logic [N-1:0] w);
    return (w & (w + ONE_N)) != '0;
  endfunction

  assign wait_last = (wcnt == WAIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_last) state_n = S_PRESENT;
      end
      S_PRESENT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = (out_idx == IDX_LAST) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Address walk and capture stage: rd_data is registered in the last WAIT
  // cycle and the converted result stays frozen throughout PRESENT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      wcnt       <= '0;
      out_idx    <= '0;
      out_count  <= '0;
      out_bubble <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_addr <= '0;
            wcnt    <= '0;
          end
        end
        S_WAIT: begin
          if (wait_last) begin
            wcnt       <= '0;
            out_idx    <= rd_addr;
            out_count  <= popcount(rd_data);
            out_bubble <= is_bubbled(rd_data);
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        S_PRESENT: begin
          if (out_ready && (out_idx != IDX_LAST)) rd_addr <= rd_addr + AW'(1);
        end
        S_DONE: begin
          rd_addr <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef TDC_READOUT_MINMAX_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_count <= CW'(N);
      max_count <= '0;
    end else if ((state == S_IDLE) && start) begin
      min_count <= CW'(N);
      max_count <= '0;
    end else if ((state == S_PRESENT) && out_ready) begin
      if (out_count < min_count) min_count <= out_count;
      if (out_count > max_count) max_count <= out_count;
    end
  end
`else
  // No pass statistics in this build; the host derives them from the stream.
`endif

endmodule

// File: tb/tb_tdc_readout.sv
// tb_tdc_readout - randomized self-checking bench for tdc_readout.
//
// A time-based reference model (when each word must appear, which word,
// what its count and bubble flag must be) is checked against the main DUT
// (RD_LATENCY = 1) on every falling edge. A second instance with
// RD_LATENCY = 2 runs the clean-pass data for latency and min/max checks.
`timescale 1ns/1ps
module tb_tdc_readout;

  localparam int N  = 16;
  localparam int T  = 8;
  localparam int L  = 1;
  localparam int L2 = 2;
  localparam int AW = $clog2(T);
  localparam int CW = $clog2(N+1);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          start, out_ready, busy, done, out_valid, out_bubble;
  logic [AW-1:0] rd_addr, out_idx;
  logic [N-1:0]  rd_data;
  logic [CW-1:0] out_count;

  logic          start2, ready2, busy2, done2, out_valid2, bubble2;
  logic [AW-1:0] rd_addr2, idx2;
  logic [N-1:0]  rd_data2;
  logic [CW-1:0] count2;

`ifdef TDC_READOUT_MINMAX_EN
  logic [CW-1:0] min_count, max_count, min2, max2;
`endif

  logic [N-1:0] mem [T];
  logic [N-1:0] clean_mem [T] = '{16'h0000, 16'h0001, 16'h0003, 16'h00FF,
                                  16'h7FFF, 16'hFFFF, 16'h000F, 16'h003F};
  int clean_cnt [T] = '{0, 1, 2, 8, 15, 16, 4, 6};

  // RAM models: single-latency data tracks the held address; double latency
  // adds one register stage behind it.
  assign rd_data = mem[rd_addr];
  always @(posedge clock) rd_data2 <= mem[rd_addr2];

  tdc_readout #(.N(N), .T(T), .RD_LATENCY(L)) u_dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_count(out_count),
    .out_bubble(out_bubble)
`ifdef TDC_READOUT_MINMAX_EN
    , .min_count(min_count), .max_count(max_count)
`endif
  );

  tdc_readout #(.N(N), .T(T), .RD_LATENCY(L2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .out_valid(out_valid2),
    .out_ready(ready2), .out_idx(idx2), .out_count(count2),
    .out_bubble(bubble2)
`ifdef TDC_READOUT_MINMAX_EN
    , .min_count(min2), .max_count(max2)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ones(input logic [N-1:0] w);
    int c = 0;
    for (int i = 0; i < N; i++) if (w[i]) c++;
    return c;
  endfunction

  function automatic bit is_thermo(input logic [N-1:0] w);
    longint unsigned v;
    for (int k = 0; k <= N; k++) begin
      v = (64'd1 << k) - 64'd1;
      if (w == v[N-1:0]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] rand_word();
    longint unsigned v;
    int k;
    if ($urandom_range(1) == 1) begin
      k = $urandom_range(N);
      v = (64'd1 << k) - 64'd1;
      return v[N-1:0];
    end
    return N'($urandom);
  endfunction

  // Reference model: a pass is a sequence of words; word m_idx becomes
  // visible L edges after the edge that requested it, is consumed on the
  // first edge that sees ready while it is visible, and the edge consuming
  // word T-1 is followed by one done cycle.
  bit m_act, m_done;
  int m_idx, vat;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act = 1'b0; m_done = 1'b0; m_idx = 0; vat = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1; m_idx = 0; vat = cyc + 1 + L;
      end
    end else if (cyc >= vat && out_ready) begin
      if (m_idx == T-1) begin
        m_act = 1'b0; m_done = 1'b1;
      end else begin
        m_idx++; vat = cyc + 1 + L;
      end
    end
  end

  bit exp_valid;
  always @(negedge clock) begin
    if (chk_en) begin
      exp_valid = m_act && (cyc >= vat);
      check("out_valid", out_valid, exp_valid);
      check("busy", busy, m_act);
      check("done", done, m_done);
      check("rd_addr", rd_addr, m_act ? m_idx : (m_done ? T-1 : 0));
      if (exp_valid) begin
        check("out_idx", out_idx, m_idx);
        check("out_count", out_count, ones(mem[m_idx]));
        check("out_bubble", out_bubble, !is_thermo(mem[m_idx]));
      end
`ifdef TDC_READOUT_MINMAX_EN
      if (m_done) begin
        int mn, mx;
        mn = N; mx = 0;
        for (int i = 0; i < T; i++) begin
          if (ones(mem[i]) < mn) mn = ones(mem[i]);
          if (ones(mem[i]) > mx) mx = ones(mem[i]);
        end
        check("min_count", min_count, mn);
        check("max_count", max_count, mx);
      end
`endif
    end
  end

  int got_cnt [T];
  bit got_bub [T];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, rd_addr, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_bubble"}, out_bubble, 0);
`ifdef TDC_READOUT_MINMAX_EN
    check({tag, "_min"}, min_count, N);
    check({tag, "_max"}, max_count, 0);
`endif
  endtask

  // One pass on the main DUT. t_done is reported in the start-relative
  // cycle numbering where start is driven in cycle 0.
  task automatic run_pass(input int rdy_pct, input int hold_idx, input int busy_idx,
                          input int rst_idx, input bit start_at_done,
                          output int n_acc, output int n_done, output int t_done,
                          output int first_idx);
    int hold_left, t0, guard;
    bit hold_used, busy_used, stop;
    n_acc = 0; n_done = 0; t_done = -1; first_idx = -1;
    hold_left = 0; hold_used = 0; busy_used = 0; stop = 0; guard = 0;
    @(negedge clock);
    start = 1'b1; out_ready = 1'b1; t0 = cyc;
    while (!stop) begin
      @(negedge clock);
      start = 1'b0;
      guard++;
      if (done) begin
        n_done++; t_done = cyc - t0 + 1; stop = 1'b1;
        if (start_at_done) start = 1'b1;
      end else if (rst_idx >= 0 && out_valid && int'(out_idx) == rst_idx) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("midpass_rst");
        @(negedge clock);
        #2 reset = 1'b0;
        stop = 1'b1;
      end else begin
        if (hold_idx >= 0 && !hold_used && out_valid && int'(out_idx) == hold_idx) begin
          hold_used = 1'b1; hold_left = 5;
        end
        if (hold_left > 0) begin
          out_ready = 1'b0; hold_left--;
        end else begin
          out_ready = ($urandom_range(99) < rdy_pct);
        end
        if (busy_idx >= 0 && !busy_used && out_valid && int'(out_idx) == busy_idx) begin
          busy_used = 1'b1; start = 1'b1;
        end
        if (out_valid && out_ready) begin
          n_acc++;
          if (first_idx < 0) first_idx = out_idx;
          got_cnt[out_idx] = out_count;
          got_bub[out_idx] = out_bubble;
        end
        if (guard > 400) begin
          check("pass_timeout", 0, 1);
          stop = 1'b1;
        end
      end
    end
    repeat (4) begin
      @(negedge clock);
      start = 1'b0;
      out_ready = 1'($urandom_range(1));
      if (done) n_done++;
    end
  endtask

  task automatic run_dut2();
    int t0, first, tdone, k, guard;
    first = -1; tdone = -1; k = 0; guard = 0;
    @(negedge clock);
    start2 = 1'b1; ready2 = 1'b1; t0 = cyc;
    @(negedge clock);
    start2 = 1'b0;
    while (tdone < 0 && guard < 200) begin
      if (out_valid2) begin
        if (first < 0) first = cyc - t0 + 1;
        check("lat2_idx", idx2, k);
        check("lat2_count", count2, clean_cnt[k]);
        check("lat2_bubble", bubble2, 0);
        k++;
      end
      if (done2) begin
        tdone = cyc - t0 + 1;
`ifdef TDC_READOUT_MINMAX_EN
        check("lat2_min", min2, 0);
        check("lat2_max", max2, 16);
`endif
      end
      guard++;
      @(negedge clock);
    end
    check("lat2_first_valid_cycle", first, 4);
    check("lat2_done_cycle", tdone, T*(L2+1)+2);
    check("lat2_results", k, T);
    check("lat2_busy_after", busy2, 0);
  endtask

  int n_acc, n_done, t_done, first_idx;

  initial begin
    start = 1'b0; out_ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    for (int i = 0; i < T; i++) mem[i] = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    chk_en = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Model pins: hand-derived values for the conversion rules.
    check("pin_cnt_00F7", ones(16'h00F7), 7);
    check("pin_bub_00F7", is_thermo(16'h00F7), 0);
    check("pin_cnt_0100", ones(16'h0100), 1);
    check("pin_bub_0100", is_thermo(16'h0100), 0);
    check("pin_clean_zero", is_thermo(16'h0000), 1);
    check("pin_clean_ones", is_thermo(16'hFFFF), 1);

    // Clean pass with ready held high.
    for (int i = 0; i < T; i++) mem[i] = clean_mem[i];
    run_pass(100, -1, -1, -1, 1'b0, n_acc, n_done, t_done, first_idx);
    check("clean_results", n_acc, T);
    check("clean_done_pulses", n_done, 1);
    check("clean_done_cycle", t_done, 18);
    check("clean_busy_after", busy, 0);
    for (int i = 0; i < T; i++) begin
      check("clean_count_lit", got_cnt[i], clean_cnt[i]);
      check("clean_bubble_lit", got_bub[i], 0);
    end

    // Bubbled snapshots under random backpressure.
    for (int i = 0; i < T; i++) mem[i] = rand_word();
    mem[2] = 16'h00F7;
    mem[5] = 16'h0100;
    run_pass(70, -1, -1, -1, 1'b0, n_acc, n_done, t_done, first_idx);
    check("bubble_results", n_acc, T);
    check("bubble_cnt_00F7", got_cnt[2], 7);
    check("bubble_flag_00F7", got_bub[2], 1);
    check("bubble_cnt_0100", got_cnt[5], 1);
    check("bubble_flag_0100", got_bub[5], 1);

    // Five-cycle stall at index 3.
    for (int i = 0; i < T; i++) mem[i] = clean_mem[i];
    run_pass(100, 3, -1, -1, 1'b0, n_acc, n_done, t_done, first_idx);
    check("stall_results", n_acc, T);
    check("stall_done_pulses", n_done, 1);
    check("stall_done_cycle", t_done, 18 + 5);

    // start pulsed while busy, and again in the done cycle.
    run_pass(100, -1, 2, -1, 1'b1, n_acc, n_done, t_done, first_idx);
    check("busy_start_results", n_acc, T);
    check("busy_start_done_pulses", n_done, 1);

    // Asynchronous reset in the middle of a pass, then a fresh pass.
    run_pass(100, -1, -1, 4, 1'b0, n_acc, n_done, t_done, first_idx);
    check("rst_pass_done_pulses", n_done, 0);
    run_pass(100, -1, -1, -1, 1'b0, n_acc, n_done, t_done, first_idx);
    check("after_rst_first_idx", first_idx, 0);
    check("after_rst_results", n_acc, T);

    // Randomized passes.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < T; i++) mem[i] = rand_word();
      run_pass($urandom_range(100, 30), -1, $urandom_range(T-1), -1,
               1'($urandom_range(1)), n_acc, n_done, t_done, first_idx);
      check("rand_results", n_acc, T);
      check("rand_done_pulses", n_done, 1);
    end

    // Two-cycle RAM latency on the clean data.
    for (int i = 0; i < T; i++) mem[i] = clean_mem[i];
    run_dut2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
